// File: rtl/codec_init_seq.sv
// Codec register-table initialiser: walks NUM_REGS {reg, val} table entries and writes each
// to the codec through an external I2C byte engine, retrying on NACK or command timeout.
module codec_init_seq #(
  parameter logic [6:0]  DEV_ADDR   = 7'h1A,
  parameter int unsigned NUM_REGS   = 10,
  parameter int unsigned RETRY_MAX  = 2,
  parameter int unsigned TIMEOUT    = 1023,
  parameter int unsigned GAP_CYCLES = 15
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        go_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic [3:0]  err_index_o,
  output logic [3:0]  tbl_addr_o,
  input  logic [15:0] tbl_data_i,
  output logic        i2c_start_o,
  output logic        i2c_stop_o,
  output logic        i2c_write_o,
  output logic [7:0]  i2c_data_o,
  input  logic        i2c_cmd_done_i,
  input  logic        i2c_cmd_status_i
);

  localparam int unsigned RetryW = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
  localparam int unsigned WaitW  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned CntW   = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES + 1) : 2;
  localparam logic [RetryW-1:0] RetryLast = RetryW'(RETRY_MAX);
  localparam logic [WaitW-1:0]  WaitLast  = WaitW'(TIMEOUT);
  localparam logic [CntW-1:0]   GapLast   = CntW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [3:0]        IdxLast   = 4'(NUM_REGS - 1);

  typedef enum logic [3:0] {
    StIdle, StFetch, StStart, StB0, StB1, StB2, StStop, StGap, StDone, StFail
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        index_q, index_d;
  logic [RetryW-1:0] retry_q, retry_d;
  logic [WaitW-1:0]  wait_q, wait_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [15:0]       entry_q, entry_d;
  logic              nack_q, nack_d;
  logic              error_q, error_d;
  logic [3:0]        err_index_q, err_index_d;
  logic              start_q, start_d;
  logic              stop_q, stop_d;
  logic              write_q, write_d;
  logic [7:0]        data_q, data_d;
  logic              timeout;
  logic              abort;
  logic              issue_start;

  assign timeout = (wait_q == WaitLast);

  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    retry_d     = retry_q;
    wait_d      = wait_q;
    cnt_d       = cnt_q;
    entry_d     = entry_q;
    nack_d      = nack_q;
    error_d     = error_q;
    err_index_d = err_index_q;
    start_d     = 1'b0;
    stop_d      = 1'b0;
    write_d     = write_q;
    data_d      = data_q;
    abort       = 1'b0;
    issue_start = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (go_i) begin
          state_d     = StFetch;
          index_d     = '0;
          retry_d     = '0;
          cnt_d       = '0;
          error_d     = 1'b0;
          err_index_d = '0;
        end
      end
      // Table data lags tbl_addr by one cycle, so sample on the second FETCH cycle.
      StFetch: begin
        if (cnt_q == CntW'(1)) begin
          entry_d     = tbl_data_i;
          issue_start = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StStart: begin
        if (!start_q) begin
          if (i2c_cmd_done_i) begin
            state_d = StB0;
            write_d = 1'b1;
            data_d  = {DEV_ADDR, 1'b0};
            wait_d  = '0;
          end else if (timeout) begin
            abort = 1'b1;
          end else begin
            wait_d = wait_q + 1'b1;
          end
        end
      end
      StB0, StB1, StB2: begin
        if (i2c_cmd_done_i) begin
          wait_d  = '0;
          write_d = 1'b0;
          if (i2c_cmd_status_i) begin
            abort = 1'b1;
          end else if (state_q == StB0) begin
            state_d = StB1;
            write_d = 1'b1;
            data_d  = entry_q[15:8];
          end else if (state_q == StB1) begin
            state_d = StB2;
            write_d = 1'b1;
            data_d  = entry_q[7:0];
          end else begin
            state_d = StStop;
            stop_d  = 1'b1;
          end
        end else if (timeout) begin
          abort = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      // A STOP that never completes still ends the attempt; the engine owns bus recovery.
      StStop: begin
        if (!stop_q) begin
          if (i2c_cmd_done_i || timeout) begin
            state_d = StGap;
            cnt_d   = '0;
          end else begin
            wait_d = wait_q + 1'b1;
          end
        end
      end
      StGap: begin
        if (cnt_q == GapLast) begin
          if (nack_q) begin
            if (retry_q < RetryLast) begin
              retry_d     = retry_q + 1'b1;
              issue_start = 1'b1;
            end else begin
              state_d     = StFail;
              error_d     = 1'b1;
              err_index_d = index_q;
            end
          end else if (index_q == IdxLast) begin
            state_d = StDone;
          end else begin
            state_d = StFetch;
            index_d = index_q + 4'd1;
            retry_d = '0;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      StFail:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (issue_start) begin
      state_d = StStart;
      start_d = 1'b1;
      wait_d  = '0;
      nack_d  = 1'b0;
    end
    if (abort) begin
      state_d = StStop;
      stop_d  = 1'b1;
      write_d = 1'b0;
      wait_d  = '0;
      nack_d  = 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      index_q     <= '0;
      retry_q     <= '0;
      wait_q      <= '0;
      cnt_q       <= '0;
      entry_q     <= '0;
      nack_q      <= 1'b0;
      error_q     <= 1'b0;
      err_index_q <= '0;
      start_q     <= 1'b0;
      stop_q      <= 1'b0;
      write_q     <= 1'b0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      retry_q     <= retry_d;
      wait_q      <= wait_d;
      cnt_q       <= cnt_d;
      entry_q     <= entry_d;
      nack_q      <= nack_d;
      error_q     <= error_d;
      err_index_q <= err_index_d;
      start_q     <= start_d;
      stop_q      <= stop_d;
      write_q     <= write_d;
      data_q      <= data_d;
    end
  end

  assign busy_o      = !(state_q inside {StIdle, StDone, StFail});
  assign done_o      = (state_q == StDone);
  assign error_o     = error_q;
  assign err_index_o = err_index_q;
  assign tbl_addr_o  = index_q;
  assign i2c_start_o = start_q;
  assign i2c_stop_o  = stop_q;
  assign i2c_write_o = write_q;
  assign i2c_data_o  = data_q;

endmodule

// File: tb/tb_codec_init_seq.sv
// Bench for codec_init_seq: behavioural I2C byte engine plus a frame-level plan model
// derived from the table, the per-entry failure pattern and the retry limit.
module tb_codec_init_seq;
  localparam int unsigned NumRegs   = 3;
  localparam int unsigned RetryMax  = 2;
  localparam int unsigned Timeout   = 1023;
  localparam int unsigned GapCycles = 15;
  localparam logic [6:0]  DevAddr   = 7'h1A;

  logic        sys_clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        go = 1'b0;
  logic        busy, done, error;
  logic [3:0]  err_index, tbl_addr;
  logic [15:0] tbl_data = '0;
  logic        i2c_start, i2c_stop, i2c_write;
  logic [7:0]  i2c_data;
  logic        cmd_done = 1'b0;
  logic        cmd_status = 1'b0;

  always #5 sys_clk = ~sys_clk;

  codec_init_seq #(
    .DEV_ADDR(DevAddr), .NUM_REGS(NumRegs), .RETRY_MAX(RetryMax),
    .TIMEOUT(Timeout), .GAP_CYCLES(GapCycles)
  ) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .go_i(go), .busy_o(busy), .done_o(done),
    .error_o(error), .err_index_o(err_index), .tbl_addr_o(tbl_addr), .tbl_data_i(tbl_data),
    .i2c_start_o(i2c_start), .i2c_stop_o(i2c_stop), .i2c_write_o(i2c_write),
    .i2c_data_o(i2c_data), .i2c_cmd_done_i(cmd_done), .i2c_cmd_status_i(cmd_status)
  );

  typedef struct {
    logic [2:0][15:0] tbl;
    logic [2:0][7:0]  fcnt;   // failing attempts per entry; 255 = never succeeds
    logic [2:0][1:0]  fbyte;  // byte (0..2) that fails
    logic [2:0]       tmo;    // failure is a missing cmd_done rather than a NACK
    bit               exp_done;
    int               exp_idx;
    int               exp_frames;
    logic [23:0]      exp_f0;
    int               exp_n0;
  } scen_t;

  typedef struct { int entry; int fail_at; bit tmo; logic [23:0] b; } plan_t;
  typedef struct { int entry; int nbytes; logic [23:0] bytes; } frame_t;

  int          n_tests = 0;
  int          n_fail = 0;
  logic [15:0] tbl_mem [16];
  plan_t       plan_q [$];
  int          lat = 2;
  int          clr_gen = 0;

  // Engine-owned observation state.
  frame_t obs_q [$];
  frame_t cur_f;
  int     cyc = 0;
  int     my_gen = 0;
  int     eng_cnt = 0;
  bit     eng_stuck = 0, eng_status = 0, eng_is_stop = 0, in_frame = 0;
  bit     have_stop = 0, excl_bad = 0;
  int     last_stop_done = 0;
  int     min_gap = 1 << 30;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Table storage answers one cycle after tbl_addr changes.
  initial begin
    logic [3:0] a = '0;
    forever begin
      @(posedge sys_clk);
      #1;
      tbl_data = tbl_mem[a];
      a = tbl_addr;
    end
  end

  initial begin
    forever begin
      @(negedge sys_clk);
      cyc++;
      cmd_done = 1'b0;
      cmd_status = 1'b0;
      if (clr_gen != my_gen) begin
        my_gen = clr_gen;
        eng_cnt = 0; eng_stuck = 0; in_frame = 0; have_stop = 0; excl_bad = 0;
        min_gap = 1 << 30;
        obs_q.delete();
      end
      if (int'(i2c_start) + int'(i2c_stop) + int'(i2c_write) > 1) excl_bad = 1;
      if (eng_stuck && !i2c_write) eng_stuck = 0;
      if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0) begin
          cmd_done = 1'b1;
          cmd_status = eng_status;
          if (eng_is_stop) begin
            last_stop_done = cyc;
            have_stop = 1;
          end
        end
      end else if (!eng_stuck) begin
        if (i2c_start) begin
          if (have_stop && (cyc - last_stop_done - 1) < min_gap) min_gap = cyc - last_stop_done - 1;
          cur_f.entry = int'(tbl_addr);
          cur_f.nbytes = 0;
          cur_f.bytes = '0;
          in_frame = 1;
          eng_status = 0; eng_is_stop = 0; eng_cnt = lat;
        end else if (i2c_stop) begin
          if (in_frame) obs_q.push_back(cur_f);
          in_frame = 0;
          eng_status = 0; eng_is_stop = 1; eng_cnt = lat;
        end else if (i2c_write) begin
          int fi;
          fi = obs_q.size();
          cur_f.bytes = {cur_f.bytes[15:0], i2c_data};
          cur_f.nbytes++;
          eng_is_stop = 0; eng_status = 0;
          if (fi < plan_q.size() && plan_q[fi].fail_at == cur_f.nbytes - 1) begin
            if (plan_q[fi].tmo) eng_stuck = 1;
            else begin eng_status = 1; eng_cnt = lat; end
          end else begin
            eng_cnt = lat;
          end
        end
      end
    end
  end

  // Expected frame list: every attempt of every entry, stopping at the first exhausted entry.
  function automatic void build_plan(scen_t s, output bit m_done, output int m_idx);
    plan_t p;
    int left, tries;
    plan_q.delete();
    m_done = 1;
    m_idx = 0;
    for (int e = 0; e < NumRegs; e++) begin
      left = int'(s.fcnt[e]);
      tries = 0;
      while (1'b1) begin
        p.entry = e;
        p.b = {DevAddr, 1'b0, s.tbl[e]};
        tries++;
        if (left > 0) begin
          p.fail_at = int'(s.fbyte[e]);
          p.tmo = s.tmo[e];
          left--;
          plan_q.push_back(p);
          if (tries > RetryMax) begin
            m_done = 0;
            m_idx = e;
            return;
          end
        end else begin
          p.fail_at = 3;
          p.tmo = 0;
          plan_q.push_back(p);
          break;
        end
      end
    end
  endfunction

  function automatic scen_t mk(logic [15:0] t0, logic [15:0] t1, logic [15:0] t2, int fe,
                               int fc, int fb, bit tm, bit ed, int ei, int ef,
                               logic [23:0] f0, int n0);
    scen_t s;
    s.tbl[0] = t0; s.tbl[1] = t1; s.tbl[2] = t2;
    s.fcnt = '0; s.fbyte = '0; s.tmo = '0;
    if (fe < 3) begin
      s.fcnt[fe] = 8'(fc);
      s.fbyte[fe] = 2'(fb);
      s.tmo[fe] = tm;
    end
    s.exp_done = ed; s.exp_idx = ei; s.exp_frames = ef; s.exp_f0 = f0; s.exp_n0 = n0;
    return s;
  endfunction

  task automatic run_scen(string nm, scen_t s, bit use_exp, bit rel);
    bit    m_done, saw_done, saw_err, e_done;
    int    m_idx, e_idx, done_cnt, en;
    logic [23:0] eb;
    saw_done = 0; saw_err = 0; done_cnt = 0;
    for (int e = 0; e < NumRegs; e++) tbl_mem[e] = s.tbl[e];
    build_plan(s, m_done, m_idx);
    e_done = use_exp ? s.exp_done : m_done;
    e_idx  = use_exp ? s.exp_idx : m_idx;
    @(posedge sys_clk);
    clr_gen++;
    @(negedge sys_clk);
    go = 1'b1;
    if (rel) rst_n = 1'b1;
    @(negedge sys_clk);
    go = 1'b0;
    check({nm, " busy after go"}, busy, 1);
    check({nm, " error cleared by go"}, error, 0);
    for (int c = 0; c < 30000; c++) begin
      go = busy && ($urandom_range(0, 31) == 0);
      @(negedge sys_clk);
      if (done || error) begin
        saw_done = done;
        saw_err = error;
        break;
      end
    end
    go = 1'b0;
    check({nm, " finished within bound"}, saw_done | saw_err, 1);
    check({nm, " busy low at end"}, busy, 0);
    check({nm, " done"}, saw_done, e_done);
    check({nm, " error"}, saw_err, !e_done);
    if (!e_done) check({nm, " err_index"}, err_index, e_idx);
    repeat (3) begin
      @(negedge sys_clk);
      if (done) done_cnt++;
    end
    check({nm, " single done pulse"}, done_cnt, 0);
    check({nm, " error held"}, error, !e_done);
    if (use_exp) begin
      check({nm, " frame count"}, obs_q.size(), s.exp_frames);
      if (obs_q.size() > 0) begin
        check({nm, " frame0 bytes"}, obs_q[0].bytes, s.exp_f0);
        check({nm, " frame0 nbytes"}, obs_q[0].nbytes, s.exp_n0);
      end
    end
    check({nm, " frames vs model"}, obs_q.size(), plan_q.size());
    for (int i = 0; i < obs_q.size() && i < plan_q.size(); i++) begin
      en = (plan_q[i].fail_at == 3) ? 3 : plan_q[i].fail_at + 1;
      eb = plan_q[i].b >> (8 * (3 - en));
      check($sformatf("%s frame%0d entry", nm, i), obs_q[i].entry, plan_q[i].entry);
      check($sformatf("%s frame%0d nbytes", nm, i), obs_q[i].nbytes, en);
      check($sformatf("%s frame%0d bytes", nm, i), obs_q[i].bytes, eb);
    end
    check({nm, " one command at a time"}, excl_bad, 0);
    if (plan_q.size() > 1) check({nm, " gap before START"}, min_gap >= GapCycles, 1);
  endtask

  scen_t vecs [5];
  scen_t rs;
  bit    found;
  int    r;

  initial begin
    vecs[0] = mk(16'h1E00, 16'hA5C3, 16'h7F01, 3, 0, 0, 0, 1, 0, 3, 24'h341E00, 3);
    vecs[1] = mk(16'h1E00, 16'h2A81, 16'h7F01, 1, 1, 1, 0, 1, 0, 4, 24'h341E00, 3);
    vecs[2] = mk(16'h1E00, 16'h2A81, 16'h7F01, 2, 255, 2, 0, 0, 2, 5, 24'h341E00, 3);
    vecs[3] = mk(16'h1E00, 16'h2A81, 16'h7F01, 0, 255, 1, 1, 0, 0, 3, 24'h00341E, 2);
    vecs[4] = mk(16'h1E00, 16'h2A81, 16'h7F01, 0, 2, 0, 0, 1, 0, 5, 24'h000034, 1);
    for (int i = 0; i < 16; i++) tbl_mem[i] = '0;

    #1 rst_n = 1'b0;
    #10;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset error", error, 0);
    check("reset i2c_start", i2c_start, 0);
    check("reset i2c_stop", i2c_stop, 0);
    check("reset i2c_write", i2c_write, 0);
    check("reset i2c_data", i2c_data, 0);
    check("reset tbl_addr", tbl_addr, 0);
    check("reset err_index", err_index, 0);

    for (int i = 0; i < 5; i++) begin
      lat = 1 + i % 3;
      run_scen($sformatf("vec%0d", i), vecs[i], 1, i == 0);
    end

    // Reset while the register byte is on the bus.
    tbl_mem[0] = 16'h1E00; tbl_mem[1] = 16'h2A81; tbl_mem[2] = 16'h7F01;
    plan_q.delete();
    @(posedge sys_clk);
    clr_gen++;
    @(negedge sys_clk);
    go = 1'b1;
    @(negedge sys_clk);
    go = 1'b0;
    found = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge sys_clk);
      if (i2c_write && i2c_data == 8'h1E) begin
        found = 1;
        break;
      end
    end
    check("midreset reached B1", found, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midreset i2c_write", i2c_write, 0);
    check("midreset busy", busy, 0);
    check("midreset i2c_stop", i2c_stop, 0);
    check("midreset tbl_addr", tbl_addr, 0);
    check("midreset i2c_data", i2c_data, 0);
    #20;
    run_scen("post-reset", vecs[0], 1, 1);

    for (int k = 0; k < 6; k++) begin
      rs = mk('0, '0, '0, 3, 0, 0, 0, 1, 0, 0, '0, 0);
      for (int e = 0; e < 3; e++) begin
        rs.tbl[e] = 16'($urandom);
        r = $urandom_range(0, 5);
        rs.fcnt[e] = (r < 3) ? 8'd0 : (r == 3) ? 8'd1 : (r == 4) ? 8'd2 : 8'd255;
        rs.fbyte[e] = 2'($urandom_range(0, 2));
        rs.tmo[e] = ($urandom_range(0, 9) == 0);
      end
      lat = $urandom_range(1, 4);
      run_scen($sformatf("rand%0d", k), rs, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/codec_init_seq.md
CODEC_INIT_SEQ -- requirements
Module: codec_init_seq

Interface
REQ-001 Parameter DEV_ADDR, 7'h1A, 7-bit I2C slave address; write-address byte = {DEV_ADDR,1'b0}.
REQ-002 Parameter NUM_REGS, 10, number of table entries issued, range 1..16.
REQ-003 Parameter RETRY_MAX, 2, NACK/timeout retries per entry before failure.
REQ-004 Parameter TIMEOUT, 1023, max sys_clk cycles waiting for one i2c_cmd_done.
REQ-005 Parameter GAP_CYCLES, 15, idle sys_clk cycles between STOP and the next START.
REQ-006 One clock; reset is asynchronous and active-low: sys_clk in 1, rst_n in 1 (asynchronous, active-low).
REQ-007 go  in  1  one-cycle pulse, start the table sequence.
REQ-008 busy  out  1  high from the cycle after an accepted go until done or error.
REQ-009 done  out  1  one-cycle pulse, all entries ACKed.
REQ-010 error  out  1  level, sequence aborted; held until next accepted go.
REQ-011 err_index  out  4  table index that failed; valid while error=1.
REQ-012 tbl_addr  out  4  table entry index.
REQ-013 tbl_data  in  16  entry {reg[6:0], val[8:0]}, valid 1 cycle after tbl_addr changes.
REQ-014 i2c_start, i2c_stop  out  1 each  one-cycle command pulses to byte engine.
REQ-015 i2c_write  out  1  level, held until byte completes.
REQ-016 i2c_data  out  8  byte to transmit, stable while i2c_write=1.
REQ-017 i2c_cmd_done  in  1  engine command-complete pulse.
REQ-018 i2c_cmd_status  in  1  sampled ACK bit with cmd_done: 0=ACK, 1=NACK.

Function
REQ-019 States: IDLE, FETCH, START, B0, B1, B2, STOP, GAP, DONE, FAIL.
REQ-020 IDLE: go=1 -> FETCH, index=0, retry=0, error cleared; go in any other state ignored.
REQ-021 FETCH: drive tbl_addr=index, wait 2 cycles, latch tbl_data into entry register -> START.
REQ-022 START: i2c_start=1 for exactly 1 cycle, then wait for i2c_cmd_done -> B0.
REQ-023 B0/B1/B2 bytes: {DEV_ADDR,0}, {reg[6:0],val[8]}, val[7:0].
REQ-024 Byte state: i2c_data set and i2c_write=1 on entry; i2c_write cleared on the edge where cmd_done is sampled 1.
REQ-025 Byte done with status 0 -> next byte state (B2 -> STOP); status 1 -> NACK path.
REQ-026 STOP: i2c_stop=1 for 1 cycle, wait cmd_done -> GAP; GAP counts GAP_CYCLES then -> FETCH (index+1) or DONE if index=NUM_REGS-1.
REQ-027 NACK path: issue STOP as REQ-026; if retry<RETRY_MAX, retry+1, return to START with same entry after GAP; else -> FAIL.
REQ-028 Retry counter reset to 0 whenever index advances.
REQ-029 Timeout: wait counter cleared on each command issue; reaching TIMEOUT without cmd_done counts as NACK (same retry/STOP path).
REQ-030 i2c_cmd_done outside a wait state ignored; at most one of i2c_start/i2c_stop/i2c_write asserted in any cycle.
REQ-031 DONE: done=1 and busy=0 in same cycle, -> IDLE next cycle.
REQ-032 FAIL: error=1, err_index=index, busy=0, -> IDLE; error holds.
REQ-033 Counters saturate at their terminal value; index never exceeds NUM_REGS-1.

Reset
REQ-034 rst_n=0 asynchronously forces IDLE; busy, done, error, i2c_start, i2c_stop, i2c_write = 0; i2c_data, tbl_addr, err_index, index, retry, counters = 0.
REQ-035 Reset mid-transaction drops i2c_write immediately; no STOP issued; bus recovery is the engine's concern.
REQ-036 First go accepted on the first sys_clk edge after rst_n deasserts.

Verification
REQ-037 Table entry 0 = 16'h1E00 (reg 0x0F, val 0), NUM_REGS=1, model ACKs all -> bytes 0x34, 0x1E, 0x00 between START and STOP; done pulse; error=0.
REQ-038 NUM_REGS=3, all ACK -> 3 START/STOP frames, >=GAP_CYCLES idle between STOP done and next i2c_start, tbl_addr 0,1,2.
REQ-039 Entry 1 NACKed on B1 once -> STOP, identical frame repeated for entry 1, sequence completes with done.
REQ-040 Entry 2 NACKs permanently, RETRY_MAX=2 -> 3 attempts, then error=1, err_index=2, no done.
REQ-041 Model never returns cmd_done after B0 -> after TIMEOUT cycles STOP issued, retries, then error=1, err_index=0.
REQ-042 rst_n pulsed low during B1 -> outputs reset same cycle; new go restarts at index 0; go while busy has no effect.
